alu_arbiter: RTL and testbench

//  Shares one combinational alu instance between two requesters (e.g. a bench/switch front end and a sequencer).

---
 rtl/alu_arbiter_if.sv | 44 ++++
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, result and alu-side signals shared between alu_arbiter and its environment.
// slave is the arbiter's view; master is the requesters' and alu's view.
interface alu_arbiter_if #(
    parameter int N = 4
);
    logic         req0;
    logic         req1;
    logic [N-1:0] a0;
    logic [N-1:0] a1;
    logic [N-1:0] b0;
    logic [N-1:0] b1;
    logic [3:0]   opc0;
    logic [3:0]   opc1;
    logic         gnt0;
    logic         gnt1;
    logic         done0;
    logic         done1;
    logic [N-1:0] res;
    logic         zero;
    logic         carry;
    logic         busy;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [2:0]   alu_op;
    logic         alu_op_sum;
    logic         alu_op_subt;
    logic [N-1:0] alu_result;
    logic         alu_carry_sum;
    logic         alu_carry_subt;

    modport slave (
        input  req0, req1, a0, a1, b0, b1, opc0, opc1,
        input  alu_result, alu_carry_sum, alu_carry_subt,
        output gnt0, gnt1, done0, done1, res, zero, carry, busy,
        output alu_a, alu_b, alu_op, alu_op_sum, alu_op_subt
    );

    modport master (
        output req0, req1, a0, a1, b0, b1, opc0, opc1,
        output alu_result, alu_carry_sum, alu_carry_subt,
        input  gnt0, gnt1, done0, done1, res, zero, carry, busy,
        input  alu_a, alu_b, alu_op, alu_op_sum, alu_op_subt
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational alu between two requesters.
// Latches the winner's operands, waits LAT cycles for the alu to settle, then returns result and flags.
//
// state  | meaning
// S_IDLE | waiting for req0/req1; grant and operand latch on the sampling edge
// S_EXEC | alu inputs stable; down-counter runs to terminal count, then capture
// S_DONE | done pulse to owner; round-robin pointer updated
module alu_arbiter #(
    parameter int N   = 4,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_last, w_last_nxt;
    logic          r_owner, w_owner_nxt;
    logic          r_gnt0, w_gnt0_nxt;
    logic          r_gnt1, w_gnt1_nxt;
    logic          r_done0, w_done0_nxt;
    logic          r_done1, w_done1_nxt;
    logic [N-1:0]  r_res, w_res_nxt;
    logic          r_zero, w_zero_nxt;
    logic          r_carry, w_carry_nxt;
    logic [N-1:0]  r_alu_a, w_alu_a_nxt;
    logic [N-1:0]  r_alu_b, w_alu_b_nxt;
    logic [2:0]    r_alu_op, w_alu_op_nxt;
    logic          r_sum, w_sum_nxt;
    logic          r_subt, w_subt_nxt;
    logic          w_pick1;
    logic [3:0]    w_opc;

    // With both requesting, the one not served last wins.
    assign w_pick1 = bus.req1 & (~bus.req0 | ~r_last);
    assign w_opc   = w_pick1 ? bus.opc1 : bus.opc0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_last   <= 1'b1;
            r_owner  <= 1'b0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_res    <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
            r_sum    <= 1'b0;
            r_subt   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_last   <= w_last_nxt;
            r_owner  <= w_owner_nxt;
            r_gnt0   <= w_gnt0_nxt;
            r_gnt1   <= w_gnt1_nxt;
            r_done0  <= w_done0_nxt;
            r_done1  <= w_done1_nxt;
            r_res    <= w_res_nxt;
            r_zero   <= w_zero_nxt;
            r_carry  <= w_carry_nxt;
            r_alu_a  <= w_alu_a_nxt;
            r_alu_b  <= w_alu_b_nxt;
            r_alu_op <= w_alu_op_nxt;
            r_sum    <= w_sum_nxt;
            r_subt   <= w_subt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_last_nxt   = r_last;
        w_owner_nxt  = r_owner;
        w_gnt0_nxt   = 1'b0;
        w_gnt1_nxt   = 1'b0;
        w_done0_nxt  = 1'b0;
        w_done1_nxt  = 1'b0;
        w_res_nxt    = r_res;
        w_zero_nxt   = r_zero;
        w_carry_nxt  = r_carry;
        w_alu_a_nxt  = r_alu_a;
        w_alu_b_nxt  = r_alu_b;
        w_alu_op_nxt = r_alu_op;
        w_sum_nxt    = r_sum;
        w_subt_nxt   = r_subt;
        case (r_state)
            S_IDLE: begin
                if (bus.req0 | bus.req1) begin
                    w_owner_nxt  = w_pick1;
                    w_alu_a_nxt  = w_pick1 ? bus.a1 : bus.a0;
                    w_alu_b_nxt  = w_pick1 ? bus.b1 : bus.b0;
                    w_alu_op_nxt = w_opc[2:0];
                    w_sum_nxt    = (w_opc == 4'b1000);
                    w_subt_nxt   = (w_opc == 4'b1001);
                    w_cnt_nxt    = CW'(LAT - 1);
                    w_gnt0_nxt   = ~w_pick1;
                    w_gnt1_nxt   = w_pick1;
                    w_state_nxt  = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_cnt == '0) begin
                    w_res_nxt   = bus.alu_result;
                    w_zero_nxt  = (bus.alu_result == '0);
                    w_carry_nxt = r_sum  ? bus.alu_carry_sum  :
                                  r_subt ? bus.alu_carry_subt : 1'b0;
                    w_done0_nxt = ~r_owner;
                    w_done1_nxt = r_owner;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_DONE: begin
                w_last_nxt  = r_owner;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.gnt0        = r_gnt0;
    assign bus.gnt1        = r_gnt1;
    assign bus.done0       = r_done0;
    assign bus.done1       = r_done1;
    assign bus.res         = r_res;
    assign bus.zero        = r_zero;
    assign bus.carry       = r_carry;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_op      = r_alu_op;
    assign bus.alu_op_sum  = r_sum;
    assign bus.alu_op_subt = r_subt;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (LAT=1 and LAT=3) share the requester stimulus,
// each driving its own behavioural alu; sel picks which instance the scenario tasks observe.
module tb_alu_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       req0, req1;
    logic [3:0] a0, a1, b0, b1, opc0, opc1;
    logic       sel;
    int         errors = 0;
    int         checks = 0;
    int         last_res = 0;

    alu_arbiter_if #(.N(N)) if1 ();
    alu_arbiter_if #(.N(N)) if3 ();

    alu_arbiter #(.N(N), .LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    alu_arbiter #(.N(N), .LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    assign if1.req0 = req0;  assign if3.req0 = req0;
    assign if1.req1 = req1;  assign if3.req1 = req1;
    assign if1.a0   = a0;    assign if3.a0   = a0;
    assign if1.a1   = a1;    assign if3.a1   = a1;
    assign if1.b0   = b0;    assign if3.b0   = b0;
    assign if1.b1   = b1;    assign if3.b1   = b1;
    assign if1.opc0 = opc0;  assign if3.opc0 = opc0;
    assign if1.opc1 = opc1;  assign if3.opc1 = opc1;

    // The shared alu instance: selects take priority over the op field.
    function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op, input logic s, input logic d);
        if (s) return a + b;
        if (d) return a - b;
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~a;
            3'd4: return a << 1;
            3'd5: return a >> 1;
            3'd6: return (b == 4'd0) ? 4'hF : a / b;
            default: return (b == 4'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic csum(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[4];
    endfunction

    always_comb begin
        if1.alu_result     = alu_fn(if1.alu_a, if1.alu_b, if1.alu_op, if1.alu_op_sum, if1.alu_op_subt);
        if1.alu_carry_sum  = csum(if1.alu_a, if1.alu_b);
        if1.alu_carry_subt = (if1.alu_a < if1.alu_b);
        if3.alu_result     = alu_fn(if3.alu_a, if3.alu_b, if3.alu_op, if3.alu_op_sum, if3.alu_op_subt);
        if3.alu_carry_sum  = csum(if3.alu_a, if3.alu_b);
        if3.alu_carry_subt = (if3.alu_a < if3.alu_b);
    end

    logic       o_gnt0, o_gnt1, o_done0, o_done1, o_zero, o_carry, o_busy, o_sum, o_subt;
    logic [3:0] o_res, o_alu_a, o_alu_b;
    logic [2:0] o_alu_op;
    assign o_gnt0   = sel ? if3.gnt0        : if1.gnt0;
    assign o_gnt1   = sel ? if3.gnt1        : if1.gnt1;
    assign o_done0  = sel ? if3.done0       : if1.done0;
    assign o_done1  = sel ? if3.done1       : if1.done1;
    assign o_res    = sel ? if3.res         : if1.res;
    assign o_zero   = sel ? if3.zero        : if1.zero;
    assign o_carry  = sel ? if3.carry       : if1.carry;
    assign o_busy   = sel ? if3.busy        : if1.busy;
    assign o_alu_a  = sel ? if3.alu_a       : if1.alu_a;
    assign o_alu_b  = sel ? if3.alu_b       : if1.alu_b;
    assign o_alu_op = sel ? if3.alu_op      : if1.alu_op;
    assign o_sum    = sel ? if3.alu_op_sum  : if1.alu_op_sum;
    assign o_subt   = sel ? if3.alu_op_subt : if1.alu_op_subt;

    // Expected outcome straight from the opcode meaning, in integer arithmetic.
    function automatic void ref_model(input int a, input int b, input logic [3:0] opc,
                                      output int res, output bit carry, output bit zero);
        int r;
        carry = 1'b0;
        if (opc == 4'b1000) begin
            r = a + b;
            carry = (r > 15);
        end else if (opc == 4'b1001) begin
            r = a - b;
            carry = (a < b);
        end else begin
            case (int'(opc) % 8)
                0: r = a & b;
                1: r = a | b;
                2: r = a ^ b;
                3: r = 15 - a;
                4: r = a * 2;
                5: r = a / 2;
                6: r = (b == 0) ? 15 : a / b;
                default: r = (b == 0) ? a : a % b;
            endcase
        end
        res  = ((r % 16) + 16) % 16;
        zero = (res == 0);
    endfunction

    function automatic int lat_of_sel();
        return sel ? 3 : 1;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((if1.gnt0 & if1.gnt1) | (if1.done0 & if1.done1) |
                (if3.gnt0 & if3.gnt1) | (if3.done0 & if3.done1)) begin
                errors++;
                $display("FAIL mutex: lat1 gnt=%b%b done=%b%b lat3 gnt=%b%b done=%b%b, required at most one hot",
                         if1.gnt1, if1.gnt0, if1.done1, if1.done0, if3.gnt1, if3.gnt0, if3.done1, if3.done0);
            end
        end
    end

    task automatic do_reset();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        last_res = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            do_reset();
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                checks++;
                if ({o_gnt0, o_gnt1, o_done0, o_done1, o_res, o_zero, o_carry, o_busy,
                     o_alu_a, o_alu_b, o_alu_op, o_sum, o_subt} !== '0) begin
                    errors++;
                    $display("FAIL reset_idle lat=%0d cyc=%0d: gnt=%b%b done=%b%b res=%h z=%b c=%b busy=%b a=%h b=%h op=%b s=%b d=%b, required all 0",
                             lat_of_sel(), i, o_gnt1, o_gnt0, o_done1, o_done0, o_res, o_zero, o_carry,
                             o_busy, o_alu_a, o_alu_b, o_alu_op, o_sum, o_subt);
                end
            end
        end
    endtask

    // One isolated request; DUT is idle on entry and on exit.
    task automatic test_single(input bit who, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] opc, input string tag);
        int er;
        bit ec, ez;
        int L;
        L = lat_of_sel();
        ref_model(int'(a), int'(b), opc, er, ec, ez);
        @(negedge clk);
        if (who) begin req1 = 1'b1; a1 = a; b1 = b; opc1 = opc; end
        else     begin req0 = 1'b1; a0 = a; b0 = b; opc0 = opc; end
        @(posedge clk); #1;
        checks++;
        if ({o_gnt1, o_gnt0} !== (who ? 2'b10 : 2'b01) || o_alu_a !== a || o_alu_b !== b ||
            o_alu_op !== opc[2:0] || o_sum !== (opc == 4'b1000) || o_subt !== (opc == 4'b1001) ||
            o_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s grant: gnt=%b%b a=%h b=%h op=%b s=%b d=%b busy=%b, required owner %0d a=%h b=%h opc=%b busy=1",
                     tag, o_gnt1, o_gnt0, o_alu_a, o_alu_b, o_alu_op, o_sum, o_subt, o_busy, who, a, b, opc);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
        opc0 = 4'($urandom); opc1 = 4'($urandom);
        for (int i = 1; i <= L; i++) begin
            @(posedge clk); #1;
            checks++;
            if (i < L) begin
                if ({o_gnt1, o_gnt0, o_done1, o_done0} !== 4'b0 || o_busy !== 1'b1 ||
                    o_res !== 4'(last_res) || o_alu_a !== a || o_alu_b !== b) begin
                    errors++;
                    $display("FAIL %s exec%0d: gnt=%b%b done=%b%b busy=%b res=%h a=%h b=%h, required quiet busy res=%h a=%h b=%h",
                             tag, i, o_gnt1, o_gnt0, o_done1, o_done0, o_busy, o_res, o_alu_a, o_alu_b,
                             4'(last_res), a, b);
                end
            end else begin
                if ({o_done1, o_done0} !== (who ? 2'b10 : 2'b01) || o_res !== 4'(er) ||
                    o_zero !== ez || o_carry !== ec) begin
                    errors++;
                    $display("FAIL %s done: done=%b%b res=%h z=%b c=%b, required owner %0d res=%h z=%b c=%b",
                             tag, o_done1, o_done0, o_res, o_zero, o_carry, who, 4'(er), ez, ec);
                end
            end
        end
        last_res = er;
        @(posedge clk); #1;
        checks++;
        if ({o_done1, o_done0} !== 2'b00 || o_busy !== 1'b0 || o_res !== 4'(er)) begin
            errors++;
            $display("FAIL %s after: done=%b%b busy=%b res=%h, required done=00 busy=0 res=%h",
                     tag, o_done1, o_done0, o_busy, o_res, 4'(er));
        end
    endtask

    task automatic test_directed();
        sel = 1'b0;
        do_reset();
        test_single(1'b0, 4'h5, 4'h3, 4'b1000, "t2_add");
        test_single(1'b1, 4'hF, 4'h1, 4'b1000, "t3_add_wrap");
        test_single(1'b1, 4'h3, 4'h5, 4'b1001, "t3_sub_borrow");
        test_single(1'b0, 4'h7, 4'h2, 4'b0110, "t5_div");
        test_single(1'b0, 4'hC, 4'h9, 4'b1011, "invalid_1011");
        test_single(1'b1, 4'h9, 4'h9, 4'b1110, "invalid_1110");
    endtask

    task automatic test_random();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            do_reset();
            for (int i = 0; i < 20; i++)
                test_single(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom_range(0, 15)), "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 2; s++) begin
            int  L, ng, nd, gcyc, er, pend;
            bit  ec, ez, exp_last;
            sel = s[0];
            L = lat_of_sel();
            ng = 0; nd = 0; gcyc = 0; er = 0; pend = 0; ec = 0; ez = 0; exp_last = 1'b1;
            rst = 1'b1;
            req0 = 1'b1; req1 = 1'b1;
            a0 = 4'($urandom); b0 = 4'($urandom); opc0 = 4'($urandom);
            a1 = 4'($urandom); b1 = 4'($urandom); opc1 = 4'($urandom);
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            for (int cyc = 0; cyc < 60 && nd < 4; cyc++) begin
                @(posedge clk); #1;
                if (o_done0 | o_done1) begin
                    nd++;
                    checks++;
                    if ({o_done1, o_done0} !== (pend != 0 ? 2'b10 : 2'b01) || o_res !== 4'(er) ||
                        o_zero !== ez || o_carry !== ec || cyc - gcyc != L) begin
                        errors++;
                        $display("FAIL b2b done lat=%0d #%0d: done=%b%b res=%h z=%b c=%b after %0d cyc, required owner %0d res=%h z=%b c=%b after %0d",
                                 L, nd, o_done1, o_done0, o_res, o_zero, o_carry, cyc - gcyc, pend,
                                 4'(er), ez, ec, L);
                    end
                    exp_last = pend[0];
                end
                if (o_gnt0 | o_gnt1) begin
                    ng++;
                    pend = exp_last ? 0 : 1;
                    checks++;
                    if ({o_gnt1, o_gnt0} !== (pend != 0 ? 2'b10 : 2'b01) ||
                        (ng > 1 && cyc - gcyc != L + 2)) begin
                        errors++;
                        $display("FAIL b2b grant lat=%0d #%0d: gnt=%b%b spacing=%0d, required owner %0d spacing %0d",
                                 L, ng, o_gnt1, o_gnt0, cyc - gcyc, pend, L + 2);
                    end
                    gcyc = cyc;
                    if (pend != 0) begin
                        ref_model(int'(a1), int'(b1), opc1, er, ec, ez);
                        a1 = 4'($urandom); b1 = 4'($urandom); opc1 = 4'($urandom);
                    end else begin
                        ref_model(int'(a0), int'(b0), opc0, er, ec, ez);
                        a0 = 4'($urandom); b0 = 4'($urandom); opc0 = 4'($urandom);
                    end
                end
            end
            checks++;
            if (nd < 4) begin
                errors++;
                $display("FAIL b2b timeout lat=%0d: dones=%0d, required 4 within 60 cycles", L, nd);
            end
            req0 = 1'b0;
            req1 = 1'b0;
            repeat (L + 4) @(posedge clk);
        end
    endtask

    task automatic test_abort();
        sel = 1'b1;
        do_reset();
        @(negedge clk);
        req0 = 1'b1; a0 = 4'h5; b0 = 4'h3; opc0 = 4'b1000;
        @(posedge clk); #1;
        checks++;
        if ({o_gnt1, o_gnt0} !== 2'b01) begin
            errors++;
            $display("FAIL abort grant: gnt=%b%b, required 01", o_gnt1, o_gnt0);
        end
        req0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({o_gnt0, o_gnt1, o_done0, o_done1, o_res, o_zero, o_carry, o_busy,
             o_alu_a, o_alu_b, o_alu_op, o_sum, o_subt} !== '0) begin
            errors++;
            $display("FAIL abort async: busy=%b a=%h b=%h s=%b, required all outputs 0",
                     o_busy, o_alu_a, o_alu_b, o_sum);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({o_done1, o_done0} !== 2'b00 || o_busy !== 1'b0 || o_res !== 4'h0) begin
                errors++;
                $display("FAIL abort no_done cyc=%0d: done=%b%b busy=%b res=%h, required 00 0 0",
                         i, o_done1, o_done0, o_busy, o_res);
            end
        end
        last_res = 0;
        test_single(1'b0, 4'h5, 4'h3, 4'b1000, "abort_resume");
    endtask

    initial begin
        sel = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0; opc0 = '0; opc1 = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
